// File: rtl/mmio_result_port.sv
// Memory-mapped result sink: captures core stores to DATA_ADDR into a small FIFO,
// drains them over a valid/ready stream and grades the first captured word.
module mmio_result_port #(
    parameter int unsigned DATA_ADDR = 200,
    parameter int unsigned STAT_ADDR = 204,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] EXPECT    = 32'h3fe00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] StatData,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        overflow,
    output logic        done,
    output logic        pass
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] DATA_A   = 32'(DATA_ADDR);
    localparam logic [31:0] STAT_A   = 32'(STAT_ADDR);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_done;
    logic          r_pass;

    logic        w_valid;
    logic        w_full;
    logic        w_push;
    logic        w_ctrl;
    logic        w_clear;
    logic        w_flush;
    logic        w_pop;
    logic        w_accept;
    logic        w_drop;
    logic [AW:0] w_inc;
    logic [AW:0] w_dec;
    logic [31:0] w_status;

    assign w_valid  = (r_count != '0);
    assign w_full   = (r_count == FULL_CNT);
    assign w_push   = MemWrite && (Adr == DATA_A);
    assign w_ctrl   = MemWrite && (Adr == STAT_A);
    assign w_clear  = w_ctrl && WriteData[0];
    assign w_flush  = w_ctrl && WriteData[1];
    assign w_pop    = w_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_inc    = {{AW{1'b0}}, w_accept};
    assign w_dec    = {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_mem[r_tail] <= WriteData;
            end
            // Flush overrides any simultaneous pop.
            if (w_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_accept) begin
                    r_tail <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                r_count <= r_count + w_inc - w_dec;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else if (w_clear) begin
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept && !r_done) begin
                r_done <= 1'b1;
                r_pass <= (WriteData == EXPECT);
            end
        end
    end

    always_comb begin
        w_status       = '0;
        w_status[0]    = w_valid;
        w_status[1]    = w_full;
        w_status[2]    = r_overflow;
        w_status[3]    = r_done;
        w_status[4]    = r_pass;
        w_status[15:8] = 8'(r_count);
    end

    assign StatData  = (Adr == STAT_A) ? w_status : 32'h0;
    assign out_valid = w_valid;
    assign out_data  = r_mem[r_head];
    assign overflow  = r_overflow;
    assign done      = r_done;
    assign pass      = r_pass;

endmodule

// File: tb/tb_mmio_result_port.sv
// Directed bench for mmio_result_port: a queue scoreboard holds the words the
// FIFO should deliver, alongside model copies of the sticky flags.
module tb_mmio_result_port;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] EXPECT = 32'h3fe00000;
    localparam logic [31:0] DADR   = 32'd200;
    localparam logic [31:0] SADR   = 32'd204;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] StatData;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        done;
    logic        pass;

    logic [31:0] expQ[$];
    logic        expOvf  = 1'b0;
    logic        expDone = 1'b0;
    logic        expPass = 1'b0;
    int          checks  = 0;
    int          errors  = 0;

    mmio_result_port #(
        .DATA_ADDR(200), .STAT_ADDR(204), .DEPTH(DEPTH), .EXPECT(EXPECT)
    ) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr),
        .WriteData(WriteData), .StatData(StatData), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .overflow(overflow),
        .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        s       = '0;
        s[0]    = (expQ.size() != 0);
        s[1]    = (expQ.size() == DEPTH);
        s[2]    = expOvf;
        s[3]    = expDone;
        s[4]    = expPass;
        s[15:8] = 8'(expQ.size());
        return s;
    endfunction

    // Drives one cycle from a negedge, updates the model and lands on the next negedge.
    task automatic applyStimulus(input logic we, input logic [31:0] adr,
                                 input logic [31:0] data, input logic rdy);
        logic popNow;
        logic accept;
        MemWrite  = we;
        Adr       = adr;
        WriteData = data;
        out_ready = rdy;
        #1;
        popNow = rdy && (expQ.size() != 0);
        if (popNow) begin
            check("popValid", 32'(out_valid), 32'd1);
            check("popData", out_data, expQ[0]);
        end
        accept = we && (adr == DADR) && ((expQ.size() < DEPTH) || popNow);
        if (popNow) void'(expQ.pop_front());
        if (accept) begin
            expQ.push_back(data);
            if (!expDone) begin
                expDone = 1'b1;
                expPass = (data == EXPECT);
            end
        end else if (we && adr == DADR) begin
            expOvf = 1'b1;
        end
        if (we && adr == SADR) begin
            if (data[0]) begin
                expOvf  = 1'b0;
                expDone = 1'b0;
                expPass = 1'b0;
            end
            if (data[1]) expQ.delete();
        end
        @(posedge clk);
        @(negedge clk);
        MemWrite  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".valid"}, 32'(out_valid), 32'(expQ.size() != 0));
        if (expQ.size() != 0) check({tag, ".data"}, out_data, expQ[0]);
        check({tag, ".ovf"}, 32'(overflow), 32'(expOvf));
        check({tag, ".done"}, 32'(done), 32'(expDone));
        if (expDone) check({tag, ".pass"}, 32'(pass), 32'(expPass));
        Adr = SADR;
        #1;
        check({tag, ".status"}, StatData, expStatus());
    endtask

    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, DADR, 32'h0, 1'b1);
        checkOutput(tag);
    endtask

    initial begin
        // Reset state, checked while reset is still held.
        #2;
        check("rstValid", 32'(out_valid), 32'd0);
        check("rstData", out_data, 32'h0);
        check("rstDone", 32'(done), 32'd0);
        check("rstPass", 32'(pass), 32'd0);
        check("rstOvf", 32'(overflow), 32'd0);
        Adr = SADR;
        #1;
        check("rstStatus", StatData, 32'h0);
        #19 reset = 1'b0;
        @(negedge clk);

        // Correct first value grades as pass.
        applyStimulus(1'b1, DADR, 32'h3fe00000, 1'b0);
        checkOutput("firstPush");
        Adr = 32'd100;
        #1;
        check("statOtherAdr", StatData, 32'h0);
        drain("drainFirst", 1);
        applyStimulus(1'b0, DADR, 32'h0, 1'b1);
        checkOutput("popEmpty");

        // Wrong first value grades as fail and stays failed.
        applyStimulus(1'b1, SADR, 32'h1, 1'b0);
        checkOutput("clear1");
        applyStimulus(1'b1, DADR, 32'h3fc00000, 1'b0);
        checkOutput("wrong1");
        applyStimulus(1'b1, DADR, 32'h3fe00000, 1'b0);
        checkOutput("wrong2");
        drain("drainWrong", 2);

        // Overflow with no consumer.
        applyStimulus(1'b1, SADR, 32'h1, 1'b0);
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, DADR, 32'(i), 1'b0);
        checkOutput("overflow");
        drain("drainOvf", 4);

        // Full FIFO accepts a push when a pop happens in the same cycle.
        applyStimulus(1'b1, SADR, 32'h1, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, DADR, 32'(i), 1'b0);
        checkOutput("full");
        applyStimulus(1'b1, DADR, 32'd9, 1'b1);
        checkOutput("fullPushPop");
        drain("drainFull", 4);

        // Address decode, then clear+flush after an overflow.
        applyStimulus(1'b1, 32'd196, 32'h11, 1'b0);
        applyStimulus(1'b1, 32'd208, 32'h22, 1'b0);
        checkOutput("decode");
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, DADR, 32'(i), 1'b0);
        checkOutput("ovf2");
        applyStimulus(1'b1, SADR, 32'h3, 1'b0);
        checkOutput("clearFlush");

        // Flush beats a simultaneous pop.
        applyStimulus(1'b1, DADR, 32'hA, 1'b0);
        applyStimulus(1'b1, DADR, 32'hB, 1'b0);
        applyStimulus(1'b1, SADR, 32'h2, 1'b1);
        checkOutput("flushPop");

        // Reset mid-stream with the consumer ready.
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, DADR, 32'(16 + i), 1'b0);
        checkOutput("preReset");
        out_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("midRstValid", 32'(out_valid), 32'd0);
        check("midRstData", out_data, 32'h0);
        expQ.delete();
        expOvf = 1'b0;
        expDone = 1'b0;
        expPass = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, DADR, 32'h55, 1'b0);
        checkOutput("postReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_result_port.md
# mmio_result_port

Memory-mapped result sink for the multi-cycle ARM core. It sits on the core's store interface (`MemWrite`, `Adr`, `WriteData`) next to the data memory and captures every store to a result address into a small FIFO. Captured words drain through a valid/ready stream. A built-in checker grades the first captured word against an expected value, which gives the self-checking bench and on-board bring-up a hardware pass/fail flag.

## Interface
- `DATA_ADDR`, default 200: byte address whose stores are captured.
- `STAT_ADDR`, default 204: status/control address.
- `DEPTH`, default 4: FIFO depth in words; a power of 2, at least 2.
- `EXPECT`, default 32'h3fe00000: expected first result (1.75, single precision).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `MemWrite` input 1: core store strobe, one cycle per store.
- `Adr` input 32: core byte address.
- `WriteData` input 32: core store data.
- `StatData` output 32: combinational status word. Equals the status fields when `Adr == STAT_ADDR`, else 0.
- `out_valid` output 1: FIFO non-empty.
- `out_data` output 32: FIFO head word (first-word-fall-through).
- `out_ready` input 1: consumer accepts the head this cycle.
- `overflow` output 1: sticky; a capture was dropped because the FIFO was full.
- `done` output 1: sticky; the checker has graded a word.
- `pass` output 1: checker verdict; meaningful only when `done`=1.

## Operation
- **Capture (push):** `MemWrite && Adr == DATA_ADDR` at a rising edge.
- **Pop:** `out_valid && out_ready` at a rising edge.
- **FIFO:** circular buffer of `DEPTH` words with head/tail pointers of log2(`DEPTH`) bits that wrap modulo `DEPTH`. `count` is log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
- **Full, push only:** the word is dropped, `overflow` is set, and pointers and `count` are unchanged.
- **Full, push and pop in the same cycle:** the pop frees the slot and the push is accepted. `count` stays `DEPTH` and `overflow` is not set.
- **Empty, push and pop in the same cycle:** impossible, because `out_valid`=0 blocks the pop. The push is accepted.
- **Pop while empty:** ignored; `out_ready` with `out_valid`=0 has no effect.
- **Checker:** on the first accepted push while `done`=0, set `done` to 1 and `pass` to (`WriteData` == `EXPECT`). Later pushes do not change `done` or `pass`. A dropped push is never graded.
- **Control write:** `MemWrite && Adr == STAT_ADDR`.
  - `WriteData[0]` = 1 clears `overflow`, `done` and `pass`.
  - `WriteData[1]` = 1 flushes the FIFO: pointers and `count` go to 0.
  - If a flush coincides with a pop, the flush wins.
  - Other bits are ignored.
- **Other addresses:** stores elsewhere are ignored entirely, as are all cycles with `MemWrite`=0.
- **Status word fields:**
  - bit0: `out_valid`
  - bit1: full
  - bit2: `overflow`
  - bit3: `done`
  - bit4: `pass`
  - [15:8]: `count`, zero-extended
  - all other bits: 0

## Timing
- **Reset values:** asserting `reset` forces at once:
  - `out_valid`=0, `overflow`=0, `done`=0, `pass`=0
  - `count`=0 and both pointers 0
  - `out_data`=0, because storage is cleared
  - `StatData` reflects the cleared state
- **Reset mid-operation:** reset asserted mid-stream discards FIFO contents with no partial pop.
- **Push latency:** a push at edge N gives `out_valid`=1 and `out_data` = the word after edge N, i.e. in cycle N+1.
- **`done`/`pass` latency:** both update at the same edge as the grading push.
- **Pop:** a pop at edge N presents the next word (or `out_valid`=0) in cycle N+1. Throughput is one word per cycle.
- **Stable until popped:** `out_data` and `out_valid` do not change while `out_valid`=1 and `out_ready`=0, except on flush or reset.
- **`StatData`:** purely combinational from current state and `Adr`; no latency.
- **Control and sticky flags:** a control write takes effect at its edge. A clear and a new capture cannot coincide, because there is a single address bus.

## Test plan
- **Reset:** hold `reset` for 22 ns, then store 32'h3fe00000 to 200. Required: `out_valid`=1 the next cycle, `out_data`=32'h3fe00000, `done`=1, `pass`=1.
- **Wrong first value:** store 32'h3fc00000 to 200, then 32'h3fe00000. Required: `done`=1, `pass`=0 and it stays 0; two words drain in order with `out_ready`=1.
- **Overflow:** with `out_ready`=0, store 1..5 to 200 (`DEPTH`=4). Required: `count`=4, `overflow`=1, and the drain yields 1,2,3,4.
- **Full push+pop:** FIFO full with 1..4; in one cycle store 9 and assert `out_ready`. Required: `count`=4, `overflow`=0, and the drain yields 2,3,4,9.
- **Address decode and control:** store to 196 and 208 and read the status word at 204. Required: status `count` 0 and no capture. Then store 3 to 204 after an overflow. Required: `overflow`, `done`, `pass` and `count` all 0.
- **Reset mid-stream:** assert `reset` with 3 words queued and `out_ready`=1. Required: `out_valid`=0 immediately; after release, a single new store gives `count`=1.
